// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pkg
//  Purpose  : Shared playfield constants, coordinate type and referee state
//             encoding for the Pong referee and its hit-test helper.
//  Contents : FIELD_MAX / WALL_TOP / WALL_BOT, COORD_W, coord_t, state_t
//  Revision : 1.0  initial release
// ============================================================================
package pong_pkg;

    localparam int FIELD_MAX = 63;
    localparam int WALL_TOP  = 0;
    localparam int WALL_BOT  = 63;

    // Coordinate width follows the playfield size (64 -> 6 bits).
    localparam int COORD_W = $clog2(FIELD_MAX + 1);

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pong_paddle_hit.sv
`default_nettype none
// ============================================================================
//  Module   : pong_paddle_hit
//  Purpose  : Combinational test of whether a ball row lies on a paddle that
//             spans rows paddle_top .. paddle_top+PADDLE_H-1.
//  Ports    : ball_y     in  6  ball row
//             paddle_top in  6  paddle top row
//             hit        out 1  ball row is covered by the paddle
//  Revision : 1.0  initial release
// ============================================================================
module pong_paddle_hit
    import pong_pkg::*;
#(
    parameter int PADDLE_H = 8
) (
    input  logic [COORD_W-1:0] ball_y,
    input  logic [COORD_W-1:0] paddle_top,
    output logic               hit
);

    // Bottom edge is formed one bit wider so a paddle near the last row does
    // not wrap around to the top; rows past the field simply cannot match.
    logic [COORD_W:0] w_bottom;

    assign w_bottom = {1'b0, paddle_top} + (COORD_W+1)'(PADDLE_H - 1);
    assign hit      = (ball_y >= paddle_top) && ({1'b0, ball_y} <= w_bottom);

endmodule
`default_nettype wire

// File: rtl/pong_referee.sv
`default_nettype none
// ============================================================================
//  Module   : pong_referee
//  Purpose  : Pong game referee. Watches ball position against paddles and
//             walls on each frame tick, keeps both scores, sequences
//             IDLE/SERVE/PLAY/POINT/OVER and pulses the event flags that the
//             ball mover reacts to. All outputs are registered.
//  Ports    : clk, reset               clock, synchronous active-high reset
//             tick                     frame strobe, gates all evaluation
//             start                    level, leaves IDLE or OVER
//             bx, by, p1_y, p2_y       ball column/row, paddle top rows
//             paddle_collision,
//             wall_collision, sc1, sc2 one-cycle event pulses
//             score1, score2           scores
//             serve_dir                0 toward player 1, 1 toward player 2
//             playing, game_over       state indicators
//             winner                   0 player 1, 1 player 2 (when over)
//  Revision : 1.0  initial release
// ============================================================================
module pong_referee
    import pong_pkg::*;
#(
    parameter int PADDLE_H    = 8,
    parameter int P1_X        = 2,
    parameter int P2_X        = 61,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic [COORD_W-1:0] p1_y,
    input  logic [COORD_W-1:0] p2_y,
    output logic               paddle_collision,
    output logic               wall_collision,
    output logic               sc1,
    output logic               sc2,
    output logic [3:0]         score1,
    output logic [3:0]         score2,
    output logic               serve_dir,
    output logic               playing,
    output logic               game_over,
    output logic               winner
);

    localparam coord_t     c_p1_x       = coord_t'(P1_X);
    localparam coord_t     c_p2_x       = coord_t'(P2_X);
    localparam coord_t     c_wall_top   = coord_t'(WALL_TOP);
    localparam coord_t     c_wall_bot   = coord_t'(WALL_BOT);
    localparam logic [3:0] c_win        = 4'(WIN_SCORE);
    localparam logic [7:0] c_serve_last = 8'(SERVE_DELAY - 1);

    state_t     r_state,   w_state_nxt;
    logic [7:0] r_cnt,     w_cnt_nxt;
    logic [3:0] r_score1,  w_score1_nxt;
    logic [3:0] r_score2,  w_score2_nxt;
    logic       r_dir,     w_dir_nxt;
    logic       r_over,    w_over_nxt;
    logic       r_winner,  w_winner_nxt;
    logic       r_playing;
    logic       r_paddle,  w_paddle_nxt;
    logic       r_wall,    w_wall_nxt;
    logic       r_sc1,     w_sc1_nxt;
    logic       r_sc2,     w_sc2_nxt;

    logic w_hit1, w_hit2, w_wall;

    pong_paddle_hit #(.PADDLE_H(PADDLE_H)) u_hit_p1 (
        .ball_y     (by),
        .paddle_top (p1_y),
        .hit        (w_hit1)
    );

    pong_paddle_hit #(.PADDLE_H(PADDLE_H)) u_hit_p2 (
        .ball_y     (by),
        .paddle_top (p2_y),
        .hit        (w_hit2)
    );

    assign w_wall = (by == c_wall_top) || (by == c_wall_bot);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_score1_nxt = r_score1;
        w_score2_nxt = r_score2;
        w_dir_nxt    = r_dir;
        w_over_nxt   = r_over;
        w_winner_nxt = r_winner;
        w_paddle_nxt = 1'b0;
        w_wall_nxt   = 1'b0;
        w_sc1_nxt    = 1'b0;
        w_sc2_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (tick && start) begin
                    w_state_nxt = SERVE;
                    w_cnt_nxt   = 8'd0;
                end
            end

            SERVE: begin
                if (tick) begin
                    if (r_cnt == c_serve_last) begin
                        w_state_nxt = PLAY;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end

            PLAY: begin
                if (tick) begin
                    // Left edge is judged before the right; a miss ends the
                    // rally and suppresses any wall flag on that frame.
                    if (bx <= c_p1_x) begin
                        if (w_hit1) begin
                            w_paddle_nxt = 1'b1;
                            w_wall_nxt   = w_wall;
                        end else begin
                            w_sc2_nxt    = 1'b1;
                            w_score2_nxt = r_score2 + 4'd1;
                            w_dir_nxt    = 1'b0;
                            w_state_nxt  = POINT;
                        end
                    end else if (bx >= c_p2_x) begin
                        if (w_hit2) begin
                            w_paddle_nxt = 1'b1;
                            w_wall_nxt   = w_wall;
                        end else begin
                            w_sc1_nxt    = 1'b1;
                            w_score1_nxt = r_score1 + 4'd1;
                            w_dir_nxt    = 1'b1;
                            w_state_nxt  = POINT;
                        end
                    end else begin
                        w_wall_nxt = w_wall;
                    end
                end
                // Back-to-back frame strobes must not stretch a pulse.
                w_paddle_nxt = w_paddle_nxt && !r_paddle;
                w_wall_nxt   = w_wall_nxt && !r_wall;
            end

            POINT: begin
                if ((r_score1 == c_win) || (r_score2 == c_win)) begin
                    w_state_nxt  = OVER;
                    w_over_nxt   = 1'b1;
                    w_winner_nxt = (r_score2 == c_win);
                end else begin
                    w_state_nxt = SERVE;
                    w_cnt_nxt   = 8'd0;
                end
            end

            OVER: begin
                if (tick && start) begin
                    w_state_nxt  = SERVE;
                    w_cnt_nxt    = 8'd0;
                    w_score1_nxt = 4'd0;
                    w_score2_nxt = 4'd0;
                    w_over_nxt   = 1'b0;
                    w_dir_nxt    = 1'b0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= 8'd0;
            r_score1  <= 4'd0;
            r_score2  <= 4'd0;
            r_dir     <= 1'b0;
            r_over    <= 1'b0;
            r_winner  <= 1'b0;
            r_playing <= 1'b0;
            r_paddle  <= 1'b0;
            r_wall    <= 1'b0;
            r_sc1     <= 1'b0;
            r_sc2     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_score1  <= w_score1_nxt;
            r_score2  <= w_score2_nxt;
            r_dir     <= w_dir_nxt;
            r_over    <= w_over_nxt;
            r_winner  <= w_winner_nxt;
            r_playing <= (w_state_nxt == PLAY);
            r_paddle  <= w_paddle_nxt;
            r_wall    <= w_wall_nxt;
            r_sc1     <= w_sc1_nxt;
            r_sc2     <= w_sc2_nxt;
        end
    end

    assign paddle_collision = r_paddle;
    assign wall_collision   = r_wall;
    assign sc1              = r_sc1;
    assign sc2              = r_sc2;
    assign score1           = r_score1;
    assign score2           = r_score2;
    assign serve_dir        = r_dir;
    assign playing          = r_playing;
    assign game_over        = r_over;
    assign winner           = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_pong_referee.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_referee
//  Purpose  : Self-checking bench for pong_referee. A rule-level game model
//             predicts every registered output each cycle; directed scenarios
//             add hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pong_referee;

    localparam int SERVE_TICKS = 32;
    localparam int WIN         = 7;

    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_SERVE = 3'd1;
    localparam logic [2:0] M_PLAY  = 3'd2;
    localparam logic [2:0] M_POINT = 3'd3;
    localparam logic [2:0] M_OVER  = 3'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [5:0] bx = 6'd0, by = 6'd0, p1_y = 6'd0, p2_y = 6'd0;

    logic       paddle_collision, wall_collision, sc1, sc2;
    logic [3:0] score1, score2;
    logic       serve_dir, playing, game_over, winner;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    pong_referee dut (
        .clk              (clk),
        .reset            (reset),
        .tick             (tick),
        .start            (start),
        .bx               (bx),
        .by               (by),
        .p1_y             (p1_y),
        .p2_y             (p2_y),
        .paddle_collision (paddle_collision),
        .wall_collision   (wall_collision),
        .sc1              (sc1),
        .sc2              (sc2),
        .score1           (score1),
        .score2           (score2),
        .serve_dir        (serve_dir),
        .playing          (playing),
        .game_over        (game_over),
        .winner           (winner)
    );

    always #5 clk = ~clk;

    // ---------------- game model ----------------
    typedef struct packed {
        logic [2:0] phase;
        logic [8:0] ticks;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       dir;
        logic       over;
        logic       win;
        logic       pc;
        logic       wc;
        logic       a1;
        logic       a2;
    } model_t;

    model_t m = '0;

    function automatic model_t step(model_t cur, logic rst, logic tk, logic st,
                                    int x, int y, int q1, int q2);
        model_t n;
        bit left, right, on1, on2, wall;
        n = cur;
        n.pc = 1'b0; n.wc = 1'b0; n.a1 = 1'b0; n.a2 = 1'b0;
        if (rst) begin
            n = '0;
            return n;
        end
        left  = (x <= 2);
        right = (x >= 61);
        on1   = (y >= q1) && (y < q1 + 8);
        on2   = (y >= q2) && (y < q2 + 8);
        wall  = (y == 0) || (y == 63);
        case (cur.phase)
            M_IDLE: if (tk && st) begin n.phase = M_SERVE; n.ticks = '0; end
            M_SERVE: if (tk) begin
                n.ticks = cur.ticks + 9'd1;
                if (int'(n.ticks) == SERVE_TICKS) n.phase = M_PLAY;
            end
            M_PLAY: if (tk) begin
                if (left && on1 || right && on2) begin
                    n.pc = 1'b1; n.wc = wall;
                end else if (left) begin
                    n.a2 = 1'b1; n.s2 = cur.s2 + 4'd1; n.dir = 1'b0; n.phase = M_POINT;
                end else if (right) begin
                    n.a1 = 1'b1; n.s1 = cur.s1 + 4'd1; n.dir = 1'b1; n.phase = M_POINT;
                end else begin
                    n.wc = wall;
                end
            end
            M_POINT: begin
                if (int'(cur.s1) == WIN || int'(cur.s2) == WIN) begin
                    n.phase = M_OVER; n.over = 1'b1; n.win = (int'(cur.s2) == WIN);
                end else begin
                    n.phase = M_SERVE; n.ticks = '0;
                end
            end
            M_OVER: if (tk && st) begin
                n.phase = M_SERVE; n.ticks = '0; n.s1 = '0; n.s2 = '0;
                n.over = 1'b0; n.dir = 1'b0;
            end
            default: n = '0;
        endcase
        return n;
    endfunction

    always @(posedge clk)
        m <= step(m, reset, tick, start, int'(bx), int'(by), int'(p1_y), int'(p2_y));

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("outputs_vs_model",
                  int'({paddle_collision, wall_collision, sc1, sc2, score1, score2,
                        serve_dir, playing, game_over, winner & game_over}),
                  int'({m.pc, m.wc, m.a1, m.a2, m.s1, m.s2,
                        m.dir, (m.phase == M_PLAY), m.over, m.win & m.over}));
        end
    end

    // ---------------- stimulus helpers ----------------
    // One tick cycle followed by one quiet cycle; returns at the negedge
    // where the tick's result is visible.
    task automatic do_tick(input int x, input int y, input int q1, input int q2);
        @(negedge clk);
        bx = 6'(x); by = 6'(y); p1_y = 6'(q1); p2_y = 6'(q2);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Ball parked on the left wall corner: a miss plus wall if play were live.
    task automatic serve_to_play();
        repeat (SERVE_TICKS) do_tick(0, 0, 40, 40);
    endtask

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_score1", int'(score1), 0);
        check("reset_flags", int'({paddle_collision, wall_collision, sc1, sc2,
                                   serve_dir, playing, game_over, winner}), 0);
        reset = 1'b0;

        // Start and serve: 31 ticks keep SERVE, the 32nd enters PLAY.
        start = 1'b1;
        do_tick(30, 30, 20, 20);
        start = 1'b0;
        repeat (SERVE_TICKS - 1) do_tick(0, 0, 40, 40);
        check("serve_31_not_playing", int'(playing), 0);
        do_tick(0, 0, 40, 40);
        check("serve_32_playing", int'(playing), 1);

        // Paddle 1 hit mid-field.
        do_tick(2, 20, 16, 40);
        check("p1_hit_pulse", int'(paddle_collision), 1);
        check("p1_hit_scores", int'({score1, score2}), 0);
        @(negedge clk);
        check("p1_hit_one_cycle", int'(paddle_collision), 0);

        // Both paddle and wall on one frame.
        do_tick(2, 0, 0, 40);
        check("hit_and_wall", int'({paddle_collision, wall_collision}), 3);

        // Boundary: paddle at 60 covers row 63 without wrapping to row 3.
        do_tick(61, 63, 0, 60);
        check("p2_edge_hit", int'({paddle_collision, sc1}), 2);
        do_tick(61, 3, 0, 60);
        check("p2_nowrap_miss", int'({sc1, wall_collision}), 2);
        check("sc1_score", int'(score1), 1);
        check("sc1_serve_dir", int'(serve_dir), 1);
        check("point_not_playing", int'(playing), 0);
        serve_to_play();

        // Player 2 wins with seven misses on the left.
        for (int i = 0; i < WIN; i++) begin
            do_tick(2, 30, 0, 40);
            if (i < WIN - 1) serve_to_play();
        end
        @(negedge clk);
        check("over_flag", int'(game_over), 1);
        check("over_winner", int'(winner), 1);
        check("over_score2", int'(score2), 7);
        check("over_serve_dir", int'(serve_dir), 0);
        repeat (3) begin
            do_tick(2, 30, 0, 40);
            check("over_no_pulse", int'({paddle_collision, wall_collision, sc1, sc2}), 0);
        end

        // Restart from OVER.
        start = 1'b1;
        do_tick(30, 30, 20, 20);
        start = 1'b0;
        check("restart_scores", int'({score1, score2}), 0);
        check("restart_over", int'(game_over), 0);
        serve_to_play();
        do_tick(61, 3, 0, 60);
        check("replay_sc1", int'(score1), 1);
        serve_to_play();
        check("replay_playing", int'(playing), 1);

        // Reset mid-play.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_all_zero", int'({paddle_collision, wall_collision, sc1, sc2,
                                         score1, score2, serve_dir, playing,
                                         game_over, winner}), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
